// File: rtl/tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tx_frame_scheduler
//
// Frame sequencer placed in front of the DCSK TX core. Host requests
// {reseed, seed, sf, msg} are queued in a small FIFO. Each frame is taken
// from the FIFO head. If the reseed flag is set, the chaos seed is loaded
// first. The block then pulses send and follows the core's busy flag until
// the frame finishes. A fixed guard gap separates consecutive frames.
//
// Parameters
//   DEPTH          request FIFO entries (power of two, >= 2)
//   GAP            idle cycles inserted after a frame completes (0 allowed)
//   START_TIMEOUT  cycles to wait for i_is_sending to rise (timeout build only)
//
// Build option
//   TX_FRAME_SCHEDULER_TIMEOUT_EN
//     defined   : WAIT_START gives up after START_TIMEOUT cycles, pulses
//                 o_err, drops the frame (no o_frame_done) and enters the gap
//     undefined : WAIT_START waits indefinitely, o_err is tied low
//
// Ports
//   i_clk          clock
//   i_rst          synchronous active-high reset (flushes FIFO, aborts frame)
//   i_valid        request valid
//   o_ready        request accepted when i_valid & o_ready (FIFO not full)
//   i_req_msg      [31:0] message payload
//   i_req_sf       [1:0]  spreading factor ID
//   i_req_seed     [7:0]  chaos seed
//   i_req_reseed   load the seed before this frame
//   o_msg          [31:0] to core message input (holding register)
//   o_sf           [1:0]  to core SF input (holding register)
//   o_seed         [7:0]  to core seed input (holding register)
//   o_load_seed    to core seed load, one-cycle pulse
//   o_send         to core send, one-cycle pulse
//   i_is_sending   from core busy flag
//   o_frame_done   one-cycle pulse per completed frame
//   o_err          one-cycle pulse on start timeout (0 in default build)
//   o_level        [$clog2(DEPTH):0] FIFO occupancy
//   o_busy         state != IDLE or FIFO non-empty
// ---------------------------------------------------------------------------
module tx_frame_scheduler #(
    parameter int DEPTH         = 4,
    parameter int GAP           = 2,
    parameter int START_TIMEOUT = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [31:0]            i_req_msg,
    input  logic [1:0]             i_req_sf,
    input  logic [7:0]             i_req_seed,
    input  logic                   i_req_reseed,
    output logic [31:0]            o_msg,
    output logic [1:0]             o_sf,
    output logic [7:0]             o_seed,
    output logic                   o_load_seed,
    output logic                   o_send,
    input  logic                   i_is_sending,
    output logic                   o_frame_done,
    output logic                   o_err,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    state_t state;

    // -----------------------------------------------------------------------
    // Request FIFO: entries are {reseed, seed, sf, msg}
    // -----------------------------------------------------------------------
    logic [42:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          push;
    logic          pop;

    logic [31:0]   head_msg;
    logic [1:0]    head_sf;
    logic [7:0]    head_seed;
    logic          head_reseed;

    // Ready depends only on the registered count, so i_valid has no
    // combinational path to o_ready.
    assign o_ready = (count != LW'(DEPTH));
    assign push    = i_valid && o_ready;
    assign pop     = (state == ST_IDLE) && (count != '0);

    assign {head_reseed, head_seed, head_sf, head_msg} = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_req_reseed, i_req_seed, i_req_sf, i_req_msg};
        end
    end

    // Pointers are exactly AW bits wide, so they wrap at DEPTH on their own.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign o_level = count;
    assign o_busy  = (state != ST_IDLE) || (count != '0);

    // The completion pulse is aligned to the cycle in which the core's busy
    // flag is first seen low. This gives the next pop exactly GAP+1 cycles
    // after the pulse.
    assign o_frame_done = (state == ST_WAIT_DONE) && !i_is_sending;

    // -----------------------------------------------------------------------
    // Frame sequencer
    // -----------------------------------------------------------------------
    logic [GW-1:0] gap_cnt;

`ifdef TX_FRAME_SCHEDULER_TIMEOUT_EN
    localparam int TW = $clog2(START_TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
`else
    assign o_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            o_msg       <= '0;
            o_sf        <= '0;
            o_seed      <= '0;
            o_load_seed <= 1'b0;
            o_send      <= 1'b0;
            gap_cnt     <= '0;
`ifdef TX_FRAME_SCHEDULER_TIMEOUT_EN
            to_cnt      <= '0;
            o_err       <= 1'b0;
`endif
        end else begin
            o_load_seed <= 1'b0;
            o_send      <= 1'b0;
`ifdef TX_FRAME_SCHEDULER_TIMEOUT_EN
            o_err       <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        o_msg <= head_msg;
                        o_sf  <= head_sf;
                        // The seed register tracks the last seed actually
                        // loaded into the core. A frame without reseed
                        // leaves the register unchanged.
                        if (head_reseed) begin
                            o_seed      <= head_seed;
                            o_load_seed <= 1'b1;
                            state       <= ST_LOAD;
                        end else begin
                            o_send <= 1'b1;
                            state  <= ST_SEND;
                        end
                    end
                end

                ST_LOAD: begin
                    o_send <= 1'b1;
                    state  <= ST_SEND;
                end

                ST_SEND: begin
                    state <= ST_WAIT_START;
`ifdef TX_FRAME_SCHEDULER_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end

                ST_WAIT_START: begin
                    if (i_is_sending) begin
                        state <= ST_WAIT_DONE;
                    end
`ifdef TX_FRAME_SCHEDULER_TIMEOUT_EN
                    else if (to_cnt == TW'(START_TIMEOUT - 1)) begin
                        // The core never started: drop the frame without
                        // a completion pulse and still honour the gap.
                        o_err <= 1'b1;
                        if (GAP == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= '0;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end

                ST_WAIT_DONE: begin
                    if (!i_is_sending) begin
                        if (GAP == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= '0;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GW'(GAP - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
`timescale 1ns/1ps
module tb_tx_frame_scheduler;

    localparam int DEPTH         = 4;
    localparam int GAP           = 2;
    localparam int START_TIMEOUT = 64;
    localparam int NEVER         = 32'h3fff_ffff;

    logic                   i_clk = 1'b0;
    logic                   i_rst;
    logic                   i_valid;
    logic                   o_ready;
    logic [31:0]            i_req_msg;
    logic [1:0]             i_req_sf;
    logic [7:0]             i_req_seed;
    logic                   i_req_reseed;
    logic [31:0]            o_msg;
    logic [1:0]             o_sf;
    logic [7:0]             o_seed;
    logic                   o_load_seed;
    logic                   o_send;
    logic                   i_is_sending;
    logic                   o_frame_done;
    logic                   o_err;
    logic [$clog2(DEPTH):0] o_level;
    logic                   o_busy;

    tx_frame_scheduler #(
        .DEPTH        (DEPTH),
        .GAP          (GAP),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_req_msg   (i_req_msg),
        .i_req_sf    (i_req_sf),
        .i_req_seed  (i_req_seed),
        .i_req_reseed(i_req_reseed),
        .o_msg       (o_msg),
        .o_sf        (o_sf),
        .o_seed      (o_seed),
        .o_load_seed (o_load_seed),
        .o_send      (o_send),
        .i_is_sending(i_is_sending),
        .o_frame_done(o_frame_done),
        .o_err       (o_err),
        .o_level     (o_level),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: a frame schedule held as absolute cycle numbers.
    // Expected times come from the rules: pop when the head has waited one
    // cycle and the previous frame's gap is over, send one or two cycles
    // after the pop, and complete when the core model drops its busy flag.
    typedef struct {
        logic [31:0] msg;
        logic [1:0]  sf;
        logic [7:0]  seed;
        logic        reseed;
        int          acc;
    } req_t;

    req_t        q[$];
    int          cyc;
    int          n_checks;
    int          n_errors;
    int          level;
    int          pop_c, load_c, send_c, done_c, err_c, free_c;
    int          is_lo, is_hi;
    logic [31:0] h_msg;
    logic [1:0]  h_sf;
    logic [7:0]  h_seed;
    bit          stall_next;
    bit          core_rand;
    int          core_d1;
    int          core_len;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int c);
        q.delete();
        level      = 0;
        pop_c      = -1;
        load_c     = -1;
        send_c     = -1;
        done_c     = -1;
        err_c      = -1;
        free_c     = c + 1;
        is_lo      = -1;
        is_hi      = -2;
        h_msg      = '0;
        h_sf       = '0;
        h_seed     = '0;
        stall_next = 1'b0;
    endtask

    task automatic run_cycle(input bit rst, input bit valid, input logic [31:0] msg,
                             input logic [1:0] sf, input logic [7:0] seed, input bit reseed);
        bit   do_pop;
        bit   do_acc;
        req_t e;
        int   d1;
        int   len;

        i_rst        = rst;
        i_valid      = valid;
        i_req_msg    = msg;
        i_req_sf     = sf;
        i_req_seed   = seed;
        i_req_reseed = reseed;
        i_is_sending = (cyc >= is_lo) && (cyc <= is_hi);

        @(negedge i_clk);
        check_eq("ready",      32'(o_ready),      32'(level < DEPTH));
        check_eq("level",      32'(o_level),      32'(level));
        check_eq("busy",       32'(o_busy),       32'(((cyc > pop_c) && (cyc < free_c)) || (level > 0)));
        check_eq("load_seed",  32'(o_load_seed),  32'(cyc == load_c));
        check_eq("send",       32'(o_send),       32'(cyc == send_c));
        check_eq("frame_done", 32'(o_frame_done), 32'(cyc == done_c));
        check_eq("err",        32'(o_err),        32'(cyc == err_c));
        check_eq("msg",        o_msg,             h_msg);
        check_eq("sf",         32'(o_sf),         32'(h_sf));
        check_eq("seed",       32'(o_seed),       32'(h_seed));

        if (rst) begin
            model_reset(cyc);
        end else begin
            do_pop = (q.size() > 0) && (q[0].acc < cyc) && (cyc >= free_c);
            do_acc = valid && (level < DEPTH);
            if (do_pop) begin
                e      = q.pop_front();
                pop_c  = cyc;
                load_c = e.reseed ? cyc + 1 : -1;
                send_c = cyc + 1 + (e.reseed ? 1 : 0);
                h_msg  = e.msg;
                h_sf   = e.sf;
                if (e.reseed) h_seed = e.seed;
                done_c = -1;
                err_c  = -1;
                if (stall_next) begin
                    stall_next = 1'b0;
                    is_lo      = -1;
                    is_hi      = -2;
`ifdef TX_FRAME_SCHEDULER_TIMEOUT_EN
                    err_c  = send_c + 1 + START_TIMEOUT;
                    free_c = err_c + GAP;
`else
                    free_c = NEVER;
`endif
                end else begin
                    d1     = core_rand ? int'($urandom_range(1, 4)) : core_d1;
                    len    = core_rand ? int'($urandom_range(1, 8)) : core_len;
                    is_lo  = send_c + d1;
                    is_hi  = send_c + d1 + len - 1;
                    done_c = send_c + d1 + len;
                    free_c = done_c + GAP + 1;
                end
            end
            if (do_acc) begin
                e.msg    = msg;
                e.sf     = sf;
                e.seed   = seed;
                e.reseed = reseed;
                e.acc    = cyc;
                q.push_back(e);
            end
            level = level + (do_acc ? 1 : 0) - (do_pop ? 1 : 0);
        end

        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic push_req(input logic [31:0] msg, input logic [1:0] sf,
                            input logic [7:0] seed, input bit reseed);
        run_cycle(1'b0, 1'b1, msg, sf, seed, reseed);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic reset_cycle();
        run_cycle(1'b1, 1'b0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        i_rst        = 1'b1;
        i_valid      = 1'b0;
        i_req_msg    = '0;
        i_req_sf     = '0;
        i_req_seed   = '0;
        i_req_reseed = 1'b0;
        i_is_sending = 1'b0;
        n_checks     = 0;
        n_errors     = 0;
        cyc          = 0;
        core_rand    = 1'b0;
        model_reset(-1);
        repeat (3) @(posedge i_clk);
        #1;

        // Single reseed frame, core busy from N+5 for 20 cycles.
        core_d1  = 2;
        core_len = 20;
        push_req(32'hDEAD_BEEF, 2'd2, 8'h5A, 1'b1);
        idle(40);

        // Six back-to-back pushes against a slow core: the sixth is refused.
        core_d1  = 1;
        core_len = 30;
        for (int i = 0; i < 6; i++) begin
            push_req($urandom, 2'($urandom), 8'($urandom), 1'($urandom));
        end
        idle(260);

        // Frame without reseed: seed register keeps the previous seed.
        core_d1  = 2;
        core_len = 5;
        push_req(32'h1234_5678, 2'd1, 8'hC3, 1'b0);
        idle(20);

        // Two queued frames separated by the guard gap.
        core_len = 4;
        push_req(32'hA5A5_0001, 2'd0, 8'h11, 1'b1);
        push_req(32'hA5A5_0002, 2'd3, 8'h22, 1'b0);
        idle(30);

        // Reset while in WAIT_DONE with two entries queued.
        core_d1  = 2;
        core_len = 30;
        push_req(32'h0BAD_0001, 2'd1, 8'h01, 1'b0);
        push_req(32'h0BAD_0002, 2'd2, 8'h02, 1'b1);
        push_req(32'h0BAD_0003, 2'd3, 8'h03, 1'b0);
        idle(7);
        reset_cycle();
        idle(40);

        // Core never starts the first frame; a second frame is queued behind it.
        stall_next = 1'b1;
        core_d1    = 1;
        core_len   = 3;
        push_req(32'h5741_1000, 2'd1, 8'h77, 1'b1);
        push_req(32'h5741_1001, 2'd2, 8'h88, 1'b0);
        idle(START_TIMEOUT + 40);
        reset_cycle();
        idle(5);

        // Random traffic with a randomly timed core and occasional resets.
        core_rand = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            run_cycle($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
                      $urandom, 2'($urandom), 8'($urandom), 1'($urandom));
        end
        idle(60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
